// File: rtl/pc_unit.sv
// pc_unit: program counter with a return-address stack.
// Supports increment, absolute load, relative branch, call and return.
// The return stack has overflow and underflow flags that stay set until cleared.
// adrs_out comes straight from a register, so no input reaches it combinationally.
module pc_unit #(
  parameter int AW       = 8,
  parameter int DEPTH    = 4,
  parameter logic [AW-1:0] RST_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           c_e,
  input  logic                           en_pc,
  input  logic [2:0]                     op,
  input  logic [AW-1:0]                  adrs_in,
  input  logic                           clr_err,
  output logic [AW-1:0]                  adrs_out,
  output logic [$clog2(DEPTH+1)-1:0]     stk_cnt,
  output logic                           stk_full,
  output logic                           stk_empty,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [AW-1:0] stack_mem [DEPTH];

  logic [AW-1:0] adrs_inc;
  logic [CW-1:0] cnt_minus;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;

  logic [AW-1:0] next_adrs;
  logic [CW-1:0] next_cnt;
  logic          do_push;
  logic          set_ovf;
  logic          set_unf;

  assign stk_full  = (stk_cnt == CW'(DEPTH));
  assign stk_empty = (stk_cnt == '0);

  assign adrs_inc  = adrs_out + AW'(1);
  assign cnt_minus = stk_cnt - CW'(1);
  // A push only happens below DEPTH and a pop only above zero.
  // Both indices therefore stay inside the storage array.
  assign push_idx  = stk_cnt[IW-1:0];
  assign pop_idx   = cnt_minus[IW-1:0];

  // Work out the next address, the next stack count and any error event for the current op.
  always_comb begin
    next_adrs = adrs_out;
    next_cnt  = stk_cnt;
    do_push   = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (en_pc) begin
      case (op)
        OP_INC:    next_adrs = adrs_inc;
        OP_LOAD:   next_adrs = adrs_in;
        // Both operands are AW bits wide, so the modular sum already sign-extends the offset.
        OP_BRANCH: next_adrs = adrs_out + adrs_in;
        OP_CALL: begin
          if (stk_full) begin
            set_ovf = 1'b1;
          end else begin
            do_push   = 1'b1;
            next_cnt  = stk_cnt + CW'(1);
            next_adrs = adrs_in;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            set_unf = 1'b1;
          end else begin
            next_adrs = stack_mem[pop_idx];
            next_cnt  = cnt_minus;
          end
        end
        default: ;
      endcase
    end
  end

  // Address, stack count and error flags, all gated by the clock enable.
  // In each flag update, a set on the same edge takes priority over clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adrs_out <= RST_ADDR;
      stk_cnt  <= '0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else if (c_e) begin
      adrs_out <= next_adrs;
      stk_cnt  <= next_cnt;
      err_ovf  <= set_ovf | (err_ovf & ~clr_err);
      err_unf  <= set_unf | (err_unf & ~clr_err);
    end
  end

  // Return-address storage, written only on a successful CALL.
  // It has no reset: the stack count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (c_e && do_push) begin
      stack_mem[push_idx] <= adrs_inc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus hand-written reset sequences for pc_unit.
module tb_pc_unit;

  logic       clk;
  logic       rst;
  logic       c_e;
  logic       en_pc;
  logic [2:0] op;
  logic [7:0] adrs_in;
  logic       clr_err;
  logic [7:0] adrs_out;
  logic [2:0] stk_cnt;
  logic       stk_full;
  logic       stk_empty;
  logic       err_ovf;
  logic       err_unf;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] INC = 3'b000, LOAD = 3'b001, BRANCH = 3'b010, CALL = 3'b011, RET = 3'b100;

  typedef struct {
    string      name;
    logic       ce;
    logic       en;
    logic [2:0] op;
    logic [7:0] ain;
    logic       clr;
    logic [7:0] exp_adrs;
    logic [2:0] exp_cnt;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t vecs[$];

  pc_unit #(.AW(8), .DEPTH(4), .RST_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .c_e(c_e), .en_pc(en_pc), .op(op), .adrs_in(adrs_in),
    .clr_err(clr_err), .adrs_out(adrs_out), .stk_cnt(stk_cnt), .stk_full(stk_full),
    .stk_empty(stk_empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(string name, logic ce, logic en, logic [2:0] o, logic [7:0] ain,
                              logic clr, logic [7:0] ea, logic [2:0] ec, logic eo, logic eu);
    vec_t v;
    v.name = name; v.ce = ce; v.en = en; v.op = o; v.ain = ain; v.clr = clr;
    v.exp_adrs = ea; v.exp_cnt = ec; v.exp_ovf = eo; v.exp_unf = eu;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic [7:0] ea, input logic [2:0] ec,
                          input logic eo, input logic eu);
    checkOutput({name, " adrs"},  adrs_out, ea);
    checkOutput({name, " cnt"},   {5'b0, stk_cnt}, {5'b0, ec});
    checkOutput({name, " full"},  {7'b0, stk_full},  {7'b0, (ec == 3'd4)});
    checkOutput({name, " empty"}, {7'b0, stk_empty}, {7'b0, (ec == 3'd0)});
    checkOutput({name, " ovf"},   {7'b0, err_ovf}, {7'b0, eo});
    checkOutput({name, " unf"},   {7'b0, err_unf}, {7'b0, eu});
  endtask

  task automatic drive(input logic ce, input logic en, input logic [2:0] o, input logic [7:0] ain,
                       input logic clr);
    @(negedge clk);
    c_e = ce; en_pc = en; op = o; adrs_in = ain; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.ce, v.en, v.op, v.ain, v.clr);
    checkAll(v.name, v.exp_adrs, v.exp_cnt, v.exp_ovf, v.exp_unf);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; c_e = 1'b0; en_pc = 1'b0; op = INC; adrs_in = 8'h00; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; c_e = 1'b0; en_pc = 1'b0; op = INC; adrs_in = 8'h00; clr_err = 1'b0;
    #1;
    checkAll("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
    doReset();
    #1;
    checkAll("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);

    // Count up, stall for one cycle, then pulse the asynchronous reset between edges.
    drive(1, 1, INC, 8'h00, 0); checkOutput("inc1", adrs_out, 8'h01);
    drive(1, 1, INC, 8'h00, 0); checkOutput("inc2", adrs_out, 8'h02);
    drive(1, 1, INC, 8'h00, 0); checkOutput("inc3", adrs_out, 8'h03);
    drive(0, 1, INC, 8'h00, 0); checkOutput("stall", adrs_out, 8'h03);
    drive(1, 1, INC, 8'h00, 0); checkOutput("inc4", adrs_out, 8'h04);
    #2 rst = 1'b0;
    #1 checkOutput("async_rst_midcycle", adrs_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Main vector table, run from the reset state.
    vecs.push_back(mk("load_fe",   1,1,LOAD,  8'hFE,0, 8'hFE,0,0,0));
    vecs.push_back(mk("inc_ff",    1,1,INC,   8'h00,0, 8'hFF,0,0,0));
    vecs.push_back(mk("inc_wrap",  1,1,INC,   8'h00,0, 8'h00,0,0,0));
    vecs.push_back(mk("load_10",   1,1,LOAD,  8'h10,0, 8'h10,0,0,0));
    vecs.push_back(mk("br_m4",     1,1,BRANCH,8'hFC,0, 8'h0C,0,0,0));
    vecs.push_back(mk("br_p5",     1,1,BRANCH,8'h05,0, 8'h11,0,0,0));
    vecs.push_back(mk("br_zero",   1,1,BRANCH,8'h00,0, 8'h11,0,0,0));
    vecs.push_back(mk("load_20",   1,1,LOAD,  8'h20,0, 8'h20,0,0,0));
    vecs.push_back(mk("call_40",   1,1,CALL,  8'h40,0, 8'h40,1,0,0));
    vecs.push_back(mk("call_50",   1,1,CALL,  8'h50,0, 8'h50,2,0,0));
    vecs.push_back(mk("ret_41",    1,1,RET,   8'h00,0, 8'h41,1,0,0));
    vecs.push_back(mk("ret_21",    1,1,RET,   8'h00,0, 8'h21,0,0,0));
    vecs.push_back(mk("call_01",   1,1,CALL,  8'h01,0, 8'h01,1,0,0));
    vecs.push_back(mk("call_02",   1,1,CALL,  8'h02,0, 8'h02,2,0,0));
    vecs.push_back(mk("call_03",   1,1,CALL,  8'h03,0, 8'h03,3,0,0));
    vecs.push_back(mk("call_04",   1,1,CALL,  8'h04,0, 8'h04,4,0,0));
    vecs.push_back(mk("call_ovf",  1,1,CALL,  8'h99,0, 8'h04,4,1,0));
    vecs.push_back(mk("en_off",    1,0,LOAD,  8'h77,0, 8'h04,4,1,0));
    vecs.push_back(mk("op_101",    1,1,3'b101,8'h77,0, 8'h04,4,1,0));
    vecs.push_back(mk("op_110",    1,1,3'b110,8'h77,0, 8'h04,4,1,0));
    vecs.push_back(mk("op_111",    1,1,3'b111,8'h77,0, 8'h04,4,1,0));
    vecs.push_back(mk("clr_no_ce", 0,1,INC,   8'h00,1, 8'h04,4,1,0));
    vecs.push_back(mk("clr_ovf",   1,0,INC,   8'h00,1, 8'h04,4,0,0));
    vecs.push_back(mk("ovf_wins",  1,1,CALL,  8'h99,1, 8'h04,4,1,0));
    vecs.push_back(mk("clr_ovf2",  1,0,INC,   8'h00,1, 8'h04,4,0,0));
    vecs.push_back(mk("ret_04",    1,1,RET,   8'h00,0, 8'h04,3,0,0));
    vecs.push_back(mk("ret_03",    1,1,RET,   8'h00,0, 8'h03,2,0,0));
    vecs.push_back(mk("ret_02",    1,1,RET,   8'h00,0, 8'h02,1,0,0));
    vecs.push_back(mk("ret_22",    1,1,RET,   8'h00,0, 8'h22,0,0,0));
    vecs.push_back(mk("ret_unf",   1,1,RET,   8'h00,0, 8'h22,0,0,1));
    vecs.push_back(mk("ret_no_ce", 0,1,LOAD,  8'h55,0, 8'h22,0,0,1));
    vecs.push_back(mk("unf_stick", 1,1,INC,   8'h00,0, 8'h23,0,0,1));
    vecs.push_back(mk("clr_unf",   1,1,INC,   8'h00,1, 8'h24,0,0,0));
    vecs.push_back(mk("unf_wins",  1,1,RET,   8'h00,1, 8'h24,0,0,1));
    vecs.push_back(mk("clr_unf2",  1,0,RET,   8'h00,1, 8'h24,0,0,0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // A reset in the middle of operation must throw away the stack contents.
    drive(1, 1, CALL, 8'h30, 0);
    drive(1, 1, CALL, 8'h31, 0);
    checkAll("pre_rst_calls", 8'h31, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    c_e = 1'b1; en_pc = 1'b1; op = RET;
    rst = 1'b0;
    #1 checkAll("rst_mid_op", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkAll("rst_held_edge", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, RET, 8'h00, 0);
    checkAll("ret_after_rst", 8'h00, 3'd0, 1'b0, 1'b1);
    drive(1, 1, INC, 8'h00, 1);
    checkAll("first_op_after_rst", 8'h01, 3'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
